mor1kx_spr_master_latte: RTL and testbench

- SPR bus initiator for the latte pipeline. It turns l.mtspr/l.mfspr requests from EXECUTE into single SPR bus transactions and holds the pipeline until it receives the responder acknowledge.
- It drives the shared spr_bus_* signals that the GPR-file, debug and other SPR responders decode.
- It guarantees that the bus strobe rises at least one clock after the instruction's request, so a responder never sees an SPR access in the same cycle as the requesting instruction's write-back.

---
 rtl/mor1kx_spr_master_latte_pkg.sv | 24 ++
 rtl/mor1kx_spr_timeout_cnt.sv | 33 +++
 rtl/mor1kx_spr_master_latte.sv | 92 +++++++++
 tb/tb_mor1kx_spr_master_latte.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_spr_master_latte_pkg.sv
// Shared SPR bus definitions: master FSM encoding, address field layout and
// the GPR-space decode that responders reuse.
package mor1kx_spr_master_latte_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_ACCESS = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int SPR_GROUP_MSB = 15;
   localparam int SPR_GROUP_LSB = 11;
   localparam int SPR_INDEX_MSB = 10;
   localparam int SPR_INDEX_LSB = 0;

   function automatic logic spr_is_gpr(input logic [15:0] addr);
      return addr[15:9] == 7'h2;
   endfunction

   function automatic logic [4:0] spr_group(input logic [15:0] addr);
      return addr[SPR_GROUP_MSB:SPR_GROUP_LSB];
   endfunction

endpackage

// File: rtl/mor1kx_spr_timeout_cnt.sv
// Saturating access-cycle counter; expired flags the cycle that is the
// MAX_CYCLES-th enabled cycle since the last clear. MAX_CYCLES=0 never expires.
module mor1kx_spr_timeout_cnt #(
   parameter int MAX_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && cnt != W'(MAX_CYCLES))
         cnt <= cnt + 1'b1;
   end

   generate
      if (MAX_CYCLES == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         assign expired = en && (cnt >= W'(MAX_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/mor1kx_spr_master_latte.sv
// SPR bus initiator: one bus transaction per l.mtspr/l.mfspr, with a dead
// cycle before the strobe and a flush-safe drain of in-flight accesses.
module mor1kx_spr_master_latte
   import mor1kx_spr_master_latte_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int SPR_TIMEOUT_CYCLES   = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pipeline_flush_i,
   input  logic                            exec_spr_req_i,
   input  logic                            exec_spr_we_i,
   input  logic [15:0]                     exec_spr_addr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] exec_spr_wdat_i,
   output logic [15:0]                     spr_bus_addr_o,
   output logic                            spr_bus_stb_o,
   output logic                            spr_bus_we_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
   input  logic                            spr_bus_ack_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
   output logic                            spr_stall_o,
   output logic                            spr_done_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] spr_rdat_o,
   output logic                            spr_timeout_o
);
   logic [2:0] state, state_nxt;
   logic       in_bus, expired, finish, to_flag, start;

   assign in_bus = (state == ST_ACCESS) || (state == ST_DRAIN);
   assign finish = in_bus && (spr_bus_ack_i || expired);
   assign start  = (state == ST_IDLE) && exec_spr_req_i && !pipeline_flush_i;

   mor1kx_spr_timeout_cnt #(.MAX_CYCLES(SPR_TIMEOUT_CYCLES)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ST_WAIT),
      .en      (in_bus),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_WAIT;
         ST_WAIT:   state_nxt = pipeline_flush_i ? ST_IDLE : ST_ACCESS;
         ST_ACCESS: begin
            if (finish)                state_nxt = pipeline_flush_i ? ST_IDLE : ST_DONE;
            else if (pipeline_flush_i) state_nxt = ST_DRAIN;
         end
         ST_DRAIN:  if (finish) state_nxt = ST_IDLE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // IDLE stall follows the request combinationally; gated so reset forces it low.
   always_comb begin
      spr_bus_stb_o = in_bus;
      spr_done_o    = (state == ST_DONE);
      spr_timeout_o = (state == ST_DONE) && to_flag;
      spr_stall_o   = (state == ST_IDLE) ? (exec_spr_req_i && rst) : (state != ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spr_bus_addr_o <= '0;
         spr_bus_we_o   <= 1'b0;
         spr_bus_dat_o  <= '0;
         spr_rdat_o     <= '0;
         to_flag        <= 1'b0;
      end else begin
         if (start) begin
            spr_bus_addr_o <= exec_spr_addr_i;
            spr_bus_we_o   <= exec_spr_we_i;
            spr_bus_dat_o  <= exec_spr_wdat_i;
         end
         // Only a non-flushed ACCESS completion reaches DONE and updates the result.
         if (state == ST_ACCESS && finish && !pipeline_flush_i) begin
            to_flag <= !spr_bus_ack_i;
            if (!spr_bus_we_o)
               spr_rdat_o <= spr_bus_ack_i ? spr_bus_dat_i : '0;
         end
      end
   end

endmodule

// File: tb/tb_mor1kx_spr_master_latte.sv
// Table-driven bench for the SPR bus master with an expected-result scoreboard.
module tb_mor1kx_spr_master_latte;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0, req = 1'b0, we = 1'b0, ack = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] wdat = '0, bus_rdat = '0;
   logic [15:0] bus_addr;
   logic        stb, bus_we, stall, done, timeout;
   logic [31:0] bus_dat, rdat;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mor1kx_spr_master_latte #(.OPTION_OPERAND_WIDTH(32), .SPR_TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst_n), .pipeline_flush_i(flush),
      .exec_spr_req_i(req), .exec_spr_we_i(we), .exec_spr_addr_i(addr), .exec_spr_wdat_i(wdat),
      .spr_bus_addr_o(bus_addr), .spr_bus_stb_o(stb), .spr_bus_we_o(bus_we), .spr_bus_dat_o(bus_dat),
      .spr_bus_ack_i(ack), .spr_bus_dat_i(bus_rdat),
      .spr_stall_o(stall), .spr_done_o(done), .spr_rdat_o(rdat), .spr_timeout_o(timeout)
   );

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdat;
      int          ack_at;    // 1-based strobe cycle carrying ack, 0 = never
      logic [31:0] rdata;
      int          flush_at;  // cycle index (0 = request cycle) to flush, -1 = none
      logic        exp_done;
      logic [31:0] exp_rdat;
      logic        exp_to;
      int          exp_stb;
      int          exp_stall; // -1 = not checked
   } vec_t;

   typedef struct {
      logic        done;
      logic [31:0] rdat;
      logic        to;
      int          stb;
      int          stall;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[10];

   function automatic vec_t mk(logic w, logic [15:0] a, logic [31:0] d, int ak, logic [31:0] rd,
                               int fl, logic ed, logic [31:0] er, logic et, int es, int est);
      vec_t v;
      v.we = w; v.addr = a; v.wdat = d; v.ack_at = ak; v.rdata = rd; v.flush_at = fl;
      v.exp_done = ed; v.exp_rdat = er; v.exp_to = et; v.exp_stb = es; v.exp_stall = est;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      exp_t got;
      int cyc = 0, stb_n = 0, first_stb = -1, stall_n = 0, done_cyc = -1;
      logic done_seen = 1'b0, to_seen = 1'b0, to_stray = 1'b0, flushed = 1'b0, fin = 1'b0;
      e.done = v.exp_done; e.rdat = v.exp_rdat; e.to = v.exp_to;
      e.stb = v.exp_stb; e.stall = v.exp_stall;
      sb.push_back(e);
      we = v.we; addr = v.addr; wdat = v.wdat;
      while (!fin && cyc < 60) begin
         @(negedge clk);
         req   = !(done_seen || flushed);
         flush = (cyc == v.flush_at);
         if (flush) flushed = 1'b1;
         if (stb) begin
            stb_n++;
            if (first_stb < 0) begin
               first_stb = cyc;
               chk("bus_addr", 64'(bus_addr), 64'(v.addr));
               chk("bus_we", 64'(bus_we), 64'(v.we));
               if (v.we) chk("bus_dat", 64'(bus_dat), 64'(v.wdat));
            end
         end
         ack      = stb && (stb_n == v.ack_at);
         bus_rdat = ack ? v.rdata : 32'h0;
         #1;
         if (stall) stall_n++;
         if (timeout) begin
            to_seen = 1'b1;
            if (!done) to_stray = 1'b1;
         end
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
         fin = (done_seen || flushed) && !stb;
         cyc++;
      end
      if (!fin) chk("txn_cycle_budget", 64'(1), 64'(0));
      @(negedge clk);
      req = 1'b0; flush = 1'b0; ack = 1'b0; bus_rdat = 32'h0;
      #1;
      chk("idle_stb", 64'(stb), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      got.done = done_seen; got.rdat = rdat; got.to = to_seen; got.stb = stb_n; got.stall = stall_n;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk("done", 64'(got.done), 64'(e.done));
         chk("rdat", 64'(got.rdat), 64'(e.rdat));
         chk("timeout", 64'(got.to), 64'(e.to));
         chk("timeout_without_done", 64'(to_stray), 64'(0));
         chk("stb_cycles", 64'(got.stb), 64'(e.stb));
         if (e.stall >= 0) chk("stall_cycles", 64'(got.stall), 64'(e.stall));
         if (e.stb > 0) chk("first_stb_cycle", 64'(first_stb), 64'(2));
         if (e.done) chk("done_latency", 64'(done_cyc), 64'(2 + e.stb));
      end
   endtask

   initial begin
      tbl[0] = mk(1, 16'h0403, 32'hDEADBEEF, 1, 32'h0,        -1, 1, 32'h0,        0, 1,  3);
      tbl[1] = mk(0, 16'h0410, 32'h0,        2, 32'h12345678, -1, 1, 32'h12345678, 0, 2,  4);
      tbl[2] = mk(0, 16'h7FF0, 32'h0,        0, 32'h0,        -1, 1, 32'h0,        1, 16, 18);
      tbl[3] = mk(1, 16'h0001, 32'h00001111, 1, 32'h0,         1, 0, 32'h0,        0, 0,  2);
      tbl[4] = mk(0, 16'h0410, 32'h0,        2, 32'hA5A5A5A5, -1, 1, 32'hA5A5A5A5, 0, 2,  4);
      tbl[5] = mk(0, 16'h0020, 32'h0,        4, 32'hFFFF0000,  2, 0, 32'hA5A5A5A5, 0, 4, -1);
      tbl[6] = mk(1, 16'h0800, 32'h0BADF00D, 3, 32'h0,        -1, 1, 32'hA5A5A5A5, 0, 3,  5);
      tbl[7] = mk(1, 16'h0403, 32'hCAFEF00D, 1, 32'h0,         2, 0, 32'hA5A5A5A5, 0, 1, -1);
      tbl[8] = mk(1, 16'h0404, 32'h12121212, 1, 32'h0,         3, 1, 32'hA5A5A5A5, 0, 1,  3);
      tbl[9] = mk(0, 16'h0401, 32'h0,        3, 32'h00C0FFEE, -1, 1, 32'h00C0FFEE, 0, 3,  5);

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stb", 64'(stb), 64'(0));
      chk("rst_stall", 64'(stall), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rdat", 64'(rdat), 64'(0));
      chk("rst_timeout", 64'(timeout), 64'(0));
      chk("rst_bus_addr", 64'(bus_addr), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // ack with no access in flight must be ignored
      @(negedge clk);
      ack = 1'b1; bus_rdat = 32'hFFFFFFFF;
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("stray_ack_stb", 64'(stb), 64'(0));
         chk("stray_ack_done", 64'(done), 64'(0));
      end
      chk("stray_ack_rdat", 64'(rdat), 64'(32'h00C0FFEE));
      ack = 1'b0; bus_rdat = 32'h0;

      // reset in the middle of an access
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0123; wdat = 32'h55555555;
      repeat (5) @(negedge clk);
      #1;
      chk("pre_rst_stb", 64'(stb), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_stb", 64'(stb), 64'(0));
      chk("midrst_stall", 64'(stall), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_rdat", 64'(rdat), 64'(0));
      chk("midrst_timeout", 64'(timeout), 64'(0));
      chk("midrst_bus_addr", 64'(bus_addr), 64'(0));
      chk("midrst_bus_we", 64'(bus_we), 64'(0));
      chk("midrst_bus_dat", 64'(bus_dat), 64'(0));
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(tbl[0]);

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
